// File: rtl/ahb_resp_mux.sv
// AHB data-phase response multiplexer.
// Captures the region select at each accepted address phase and steers
// HRDATA/HREADY/HRESP back from the selected region. Region 0 (unmapped)
// is answered by a built-in default slave that produces the two-cycle
// AHB ERROR response.
module ahb_resp_mux #(
   parameter int unsigned XLEN = 64,
   parameter int unsigned NR   = 14
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NR-1:0]      HSELRegions,
   input  logic [1:0]         HTRANS,
   input  logic [NR*XLEN-1:0] HRDATAIn,
   input  logic [NR-1:0]      HREADYOUTIn,
   input  logic [NR-1:0]      HRESPIn,
   output logic [XLEN-1:0]    HRDATA,
   output logic               HREADY,
   output logic               HRESP,
   output logic [NR-1:0]      HSELDataPhase,
   output logic               MultiSelErr
);

   // Default-slave error sequencer states.
   typedef enum logic [1:0] {
      StIdle,
      StErr1,
      StErr2
   } err_state_e;

   localparam logic [NR-1:0] OneSel = NR'(1);

   err_state_e state_q, state_d;

   logic [NR-1:0]   sel_dp_q;
   logic            multi_q;

   logic            accept;
   logic            active_xfer;
   logic            sel_region0;
   logic            sel_multi;

   logic            err_ready;
   logic            err_resp;

   logic            act_found;
   logic            act_zero;
   logic [XLEN-1:0] mux_rdata;
   logic            mux_ready;
   logic            mux_resp;

   // Slice 0 of the per-region buses and HTRANS[0] carry no information here.
   logic            unused_inputs;
   assign unused_inputs = ^{HTRANS[0], HRDATAIn[XLEN-1:0], HREADYOUTIn[0], HRESPIn[0]};

   // HREADY doubles as the address-phase accept strobe.
   assign accept      = HREADY;
   assign active_xfer = HTRANS[1];
   // Bit 0 is the lowest bit, so it wins whenever it is set.
   assign sel_region0 = active_xfer & HSELRegions[0];
   // More than one bit set: clearing the lowest set bit leaves something.
   assign sel_multi   = active_xfer & ((HSELRegions & (HSELRegions - OneSel)) != '0);

   // Data-phase select register: loads on accept, holds through wait states.
   always_ff @(posedge clk) begin
      if (reset) begin
         sel_dp_q <= '0;
      end else if (accept) begin
         sel_dp_q <= active_xfer ? HSELRegions : '0;
      end
   end

   // One-cycle pulse flagging an accepted multi-hot select.
   always_ff @(posedge clk) begin
      if (reset) begin
         multi_q <= 1'b0;
      end else begin
         multi_q <= accept & sel_multi;
      end
   end

   // Default-slave state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Default-slave next state: ERR1 always advances, ERR2 may chain into a new error.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (accept && sel_region0) begin
               state_d = StErr1;
            end
         end
         StErr1: begin
            state_d = StErr2;
         end
         StErr2: begin
            state_d = (accept && sel_region0) ? StErr1 : StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Default-slave outputs: ERR1 stalls with ERROR, ERR2 completes it.
   always_comb begin
      err_ready = 1'b1;
      err_resp  = 1'b0;
      case (state_q)
         StIdle: begin
            err_ready = 1'b1;
            err_resp  = 1'b0;
         end
         StErr1: begin
            err_ready = 1'b0;
            err_resp  = 1'b1;
         end
         StErr2: begin
            err_ready = 1'b1;
            err_resp  = 1'b1;
         end
         default: begin
            err_ready = 1'b1;
            err_resp  = 1'b0;
         end
      endcase
   end

   // Priority pick of the lowest set data-phase select bit and its response slice.
   always_comb begin
      act_found = 1'b0;
      act_zero  = 1'b0;
      mux_rdata = '0;
      mux_ready = 1'b1;
      mux_resp  = 1'b0;
      for (int unsigned i = 0; i < NR; i++) begin
         if (!act_found && sel_dp_q[i]) begin
            act_found = 1'b1;
            if (i == 0) begin
               act_zero = 1'b1;
            end else begin
               mux_rdata = HRDATAIn[i*XLEN +: XLEN];
               mux_ready = HREADYOUTIn[i];
               mux_resp  = HRESPIn[i];
            end
         end
      end
   end

   // Final response: default slave for region 0, region mux otherwise
   // (the mux already reads as an idle data phase when nothing is selected).
   always_comb begin
      if (act_zero) begin
         HRDATA = '0;
         HREADY = err_ready;
         HRESP  = err_resp;
      end else begin
         HRDATA = mux_rdata;
         HREADY = mux_ready;
         HRESP  = mux_resp;
      end
   end

   assign HSELDataPhase = sel_dp_q;
   assign MultiSelErr   = multi_q;

endmodule

// File: tb/tb_ahb_resp_mux.sv
// Self-checking bench for ahb_resp_mux: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// transaction-level model of the data phase.
module tb_ahb_resp_mux;

   localparam int XLEN = 64;
   localparam int NR   = 14;

   logic               clk = 1'b0;
   logic               reset;
   logic [NR-1:0]      hsel;
   logic [1:0]         htrans;
   logic [NR*XLEN-1:0] hrdata_in;
   logic [NR-1:0]      hreadyout_in;
   logic [NR-1:0]      hresp_in;
   logic [XLEN-1:0]    hrdata;
   logic               hready;
   logic               hresp;
   logic [NR-1:0]      hsel_dp;
   logic               multi_err;

   int n_checks = 0;
   int n_fail   = 0;
   bit check_en = 1'b0;

   // Model state: accepted select, how far into an ERROR response we are, multi-hot flag.
   logic [NR-1:0] m_sel   = '0;
   int            m_err   = 0;
   bit            m_multi = 1'b0;

   ahb_resp_mux #(
      .XLEN(XLEN),
      .NR  (NR)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .HSELRegions  (hsel),
      .HTRANS       (htrans),
      .HRDATAIn     (hrdata_in),
      .HREADYOUTIn  (hreadyout_in),
      .HRESPIn      (hresp_in),
      .HRDATA       (hrdata),
      .HREADY       (hready),
      .HRESP        (hresp),
      .HSELDataPhase(hsel_dp),
      .MultiSelErr  (multi_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int lowest(input logic [NR-1:0] v);
      for (int i = 0; i < NR; i++) begin
         if (v[i]) return i;
      end
      return -1;
   endfunction

   // Expected combinational outputs for the current cycle.
   task automatic model_out(output logic [XLEN-1:0] rd, output logic rdy, output logic rsp);
      int r;
      r = lowest(m_sel);
      if (r < 0) begin
         rd = '0; rdy = 1'b1; rsp = 1'b0;
      end else if (r == 0) begin
         rd = '0; rdy = (m_err == 2); rsp = 1'b1;
      end else begin
         rd = hrdata_in[r*XLEN +: XLEN]; rdy = hreadyout_in[r]; rsp = hresp_in[r];
      end
   endtask

   // Model advance at each rising edge.
   always @(posedge clk) begin
      logic [XLEN-1:0] rd;
      logic            rdy, rsp;
      model_out(rd, rdy, rsp);
      if (reset) begin
         m_sel = '0; m_err = 0; m_multi = 1'b0;
      end else begin
         m_multi = rdy && htrans[1] && ($countones(hsel) > 1);
         if (rdy) begin
            m_sel = htrans[1] ? hsel : '0;
            m_err = (lowest(m_sel) == 0) ? 1 : 0;
         end else if (m_err == 1) begin
            m_err = 2;
         end
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      logic [XLEN-1:0] rd;
      logic            rdy, rsp;
      if (check_en) begin
         model_out(rd, rdy, rsp);
         check("model HRDATA", hrdata, rd);
         check("model HREADY", {63'd0, hready}, {63'd0, rdy});
         check("model HRESP", {63'd0, hresp}, {63'd0, rsp});
         check("model HSELDataPhase", {50'd0, hsel_dp}, {50'd0, m_sel});
         check("model MultiSelErr", {63'd0, multi_err}, {63'd0, m_multi});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_rr(input string name, input logic rdy, input logic rsp);
      @(negedge clk);
      check({name, " HREADY"}, {63'd0, hready}, {63'd0, rdy});
      check({name, " HRESP"}, {63'd0, hresp}, {63'd0, rsp});
   endtask

   initial begin
      reset        = 1'b1;
      hsel         = '0;
      htrans       = 2'b00;
      hrdata_in    = '0;
      hreadyout_in = '1;
      hresp_in     = '0;
      repeat (2) @(posedge clk);
      #1;
      reset    = 1'b0;
      check_en = 1'b1;

      // Reset state
      @(negedge clk);
      check("reset HREADY", {63'd0, hready}, 64'd1);
      check("reset HRESP", {63'd0, hresp}, 64'd0);
      check("reset HRDATA", hrdata, 64'd0);
      check("reset HSELDataPhase", {50'd0, hsel_dp}, 64'd0);
      check("reset MultiSelErr", {63'd0, multi_err}, 64'd0);

      // UART read
      tick();
      hsel = 14'h0100; htrans = 2'b10; hrdata_in[8*XLEN +: XLEN] = 64'hA5;
      tick();
      hsel = '0; htrans = 2'b00;
      @(negedge clk);
      check("uart HRDATA", hrdata, 64'hA5);
      chk_rr("uart", 1'b1, 1'b0);

      // Single unmapped transfer
      tick();
      hsel = 14'h0001; htrans = 2'b10;
      tick();
      hsel = '0; htrans = 2'b00;
      chk_rr("unmapped err1", 1'b0, 1'b1);
      tick();
      chk_rr("unmapped err2", 1'b1, 1'b1);
      tick();
      chk_rr("unmapped done", 1'b1, 1'b0);

      // Two consecutive unmapped transfers
      hsel = 14'h0001; htrans = 2'b10;
      tick();
      chk_rr("b2b err1a", 1'b0, 1'b1);
      tick();
      chk_rr("b2b err2a", 1'b1, 1'b1);
      tick();
      hsel = '0; htrans = 2'b00;
      chk_rr("b2b err1b", 1'b0, 1'b1);
      tick();
      chk_rr("b2b err2b", 1'b1, 1'b1);
      tick();
      chk_rr("b2b done", 1'b1, 1'b0);

      // Extended data phase on region 6
      hsel = 14'h0040; htrans = 2'b10; hreadyout_in[6] = 1'b0;
      tick();
      hsel = 14'h0080;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("stall HREADY", {63'd0, hready}, 64'd0);
         check("stall HSELDataPhase", {50'd0, hsel_dp}, 64'h0040);
         tick();
      end
      hreadyout_in[6] = 1'b1;
      @(negedge clk);
      check("stall release HREADY", {63'd0, hready}, 64'd1);
      tick();
      hsel = '0; htrans = 2'b00;
      @(negedge clk);
      check("stall next HSELDataPhase", {50'd0, hsel_dp}, 64'h0080);
      tick();

      // Multi-hot select: lowest bit wins
      hrdata_in[1*XLEN +: XLEN] = 64'h1111_2222_3333_4444;
      hrdata_in[2*XLEN +: XLEN] = 64'h5555_6666_7777_8888;
      hsel = 14'h0006; htrans = 2'b10;
      tick();
      hsel = '0; htrans = 2'b00;
      @(negedge clk);
      check("multi MultiSelErr", {63'd0, multi_err}, 64'd1);
      check("multi HRDATA", hrdata, 64'h1111_2222_3333_4444);
      tick();
      @(negedge clk);
      check("multi pulse end", {63'd0, multi_err}, 64'd0);

      // Reset during ERR1
      tick();
      hsel = 14'h0001; htrans = 2'b10;
      tick();
      hsel = '0; htrans = 2'b00; reset = 1'b1;
      chk_rr("rst err1", 1'b0, 1'b1);
      tick();
      reset = 1'b0;
      chk_rr("rst after", 1'b1, 1'b0);
      check("rst after HSELDataPhase", {50'd0, hsel_dp}, 64'd0);
      check("rst after HRDATA", hrdata, 64'd0);

      // Reset wins over a concurrent address phase
      tick();
      reset = 1'b1; hsel = 14'h0100; htrans = 2'b10;
      tick();
      reset = 1'b0; hsel = '0; htrans = 2'b00;
      @(negedge clk);
      check("rst priority HSELDataPhase", {50'd0, hsel_dp}, 64'd0);

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         tick();
         reset  = ($urandom_range(0, 99) == 0);
         htrans = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 9))
            0:       hsel = '0;
            1:       hsel = NR'($urandom) | NR'($urandom);
            default: hsel = NR'(1) << $urandom_range(0, NR - 1);
         endcase
         for (int i = 0; i < NR; i++) begin
            hrdata_in[i*XLEN +: XLEN] = {$urandom(), $urandom()};
            hreadyout_in[i] = ($urandom_range(0, 3) != 0);
            hresp_in[i]     = ($urandom_range(0, 7) == 0);
         end
      end
      tick();
      @(negedge clk);
      #1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ahb_resp_mux.md
AHB_RESP_MUX -- requirements
Module: ahb_resp_mux

Interface
REQ-001 Parameter: XLEN, default 64, data bus width in bits.
REQ-002 Parameter: NR, default 14, number of region select lines; bit 0 is "no region selected" (unmapped); bits NR-1:1 are peripherals/memories.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 HSELRegions  input  NR  address-phase region select from the address decoder, one-hot expected.
REQ-006 HTRANS  input  2  AHB transfer type; bit 1 set = NONSEQ/SEQ (active transfer).
REQ-007 HRDATAIn  input  NR*XLEN  flattened read data; slice i = region i; slice 0 ignored.
REQ-008 HREADYOUTIn  input  NR  per-region ready; bit 0 ignored.
REQ-009 HRESPIn  input  NR  per-region error response; bit 0 ignored.
REQ-010 HRDATA  output  XLEN  muxed data-phase read data.
REQ-011 HREADY  output  1  muxed bus ready, also used internally as the address-phase accept strobe.
REQ-012 HRESP  output  1  muxed error response.
REQ-013 HSELDataPhase  output  NR  registered data-phase select.
REQ-014 MultiSelErr  output  1  one-cycle pulse when a multi-hot select is accepted.

Function
REQ-015 Address phase accepted on any rising edge with HREADY=1.
REQ-016 On accept: HSELDataPhase <= HTRANS[1] ? HSELRegions : 0; when HREADY=0, HSELDataPhase holds.
REQ-017 Active region = lowest set bit of HSELDataPhase; none set = idle data phase.
REQ-018 Idle data phase: HREADY=1, HRESP=0, HRDATA=0.
REQ-019 Active region i>=1: HRDATA=HRDATAIn slice i, HREADY=HREADYOUTIn[i], HRESP=HRESPIn[i]; purely combinational from HSELDataPhase.
REQ-020 Active region 0: driven by the default-slave FSM with states IDLE, ERR1, ERR2; HRDATA=0.
REQ-021 IDLE -> ERR1 when an accepted address phase has HTRANS[1]=1 and HSELRegions[0]=1 as the lowest set bit.
REQ-022 ERR1: HREADY=0, HRESP=1; always -> ERR2 next cycle.
REQ-023 ERR2: HREADY=1, HRESP=1 (completes the two-cycle AHB ERROR response).
REQ-024 Exit from ERR2: -> ERR1 if the transfer accepted in that cycle again selects region 0 with HTRANS[1]=1; else -> IDLE.
REQ-025 Back-to-back transfers to different regions: no bubble; the mux follows HSELDataPhase from the cycle after accept.
REQ-026 MultiSelErr: pulses for one cycle on the cycle after a multi-hot HSELRegions is accepted with HTRANS[1]=1; the lowest bit still wins.
REQ-027 Extended data phase (HREADYOUTIn[i]=0 for N cycles): HREADY=0 for N cycles; no new address is captured.

Reset
REQ-028 reset=1 at an edge: HSELDataPhase=0, FSM=IDLE, MultiSelErr=0; outputs then read HREADY=1, HRESP=0, HRDATA=0.
REQ-029 Reset in ERR1 or ERR2 aborts the error response; the cycle after reset is an idle data phase.
REQ-030 Reset takes priority over accept; no transfer is captured on the reset edge.

Verification
REQ-031 Reset, then HTRANS=2'b10, HSELRegions=14'h0100 (UART), HREADYOUTIn[8]=1, slice 8=64'hA5 -> next cycle HRDATA=64'hA5, HREADY=1, HRESP=0.
REQ-032 HSELRegions=14'h0001, HTRANS=2'b10 -> cycle+1: HREADY=0, HRESP=1; cycle+2: HREADY=1, HRESP=1; cycle+3 (HTRANS=0): HREADY=1, HRESP=0.
REQ-033 Two consecutive unmapped transfers -> HREADY/HRESP sequence 0/1, 1/1, 0/1, 1/1, then 1/0.
REQ-034 Region 6 held with HREADYOUTIn[6]=0 for 3 cycles while HSELRegions changes to 14'h0080 -> HREADY=0 for 3 cycles, HSELDataPhase stays 14'h0040, then 14'h0080 is captured.
REQ-035 HSELRegions=14'h0006, HTRANS=2'b10 -> MultiSelErr=1 for one cycle; data comes from region 1.
REQ-036 reset asserted during ERR1 -> next cycle HREADY=1, HRESP=0, FSM=IDLE, HSELDataPhase=0.
